// File: rtl/raddr_channel_pkg.sv
// Shared constants, FSM encoding and helpers for the AXI read-address generator.
package raddr_channel_pkg;

  localparam int unsigned BEAT_BYTES = 128;
  localparam int unsigned BEAT_SHIFT = 7;
  localparam int unsigned HDR_BEATS  = 6;
  localparam int unsigned MB_BEATS   = 3;

  localparam logic [2:0] AXI_SIZE_128B  = 3'b111;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Total beats for one region: parameter header plus three beats per macroblock.
  function automatic logic [31:0] total_beats(input logic [23:0] mb_num);
    return 32'(HDR_BEATS) + 32'(MB_BEATS) * {8'd0, mb_num};
  endfunction

endpackage

// File: rtl/raddr_channel_if.sv
// AXI read-address channel bundle; master drives the request, slave returns arready.
interface raddr_channel_if #(
  parameter int ID_WIDTH = 2
);

  logic [63:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [ID_WIDTH-1:0] arid;
  logic                arvalid;
  logic                arready;

  modport master (
    output araddr, arlen, arsize, arburst, arid, arvalid,
    input  arready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arid, arvalid,
    output arready
  );

endinterface

// File: rtl/raddr_burst_calc.sv
// Burst length for the next request: min(beats remaining, MAX_BURST, beats left in the 4 KB page).
module raddr_burst_calc #(
  parameter int unsigned MAX_BURST = 32
) (
  input  logic [31:0] remaining_i,
  input  logic [4:0]  beat_in_page_i,
  output logic [5:0]  len_o
);

  logic [5:0] room;
  logic [5:0] cap;

  // Clamp against the burst limit first, then against the page boundary.
  always_comb begin
    // NOTE: every combinational output gets a value on every path so no latch is inferred.
    room  = 6'd32 - {1'b0, beat_in_page_i};
    cap   = (remaining_i < 32'(MAX_BURST)) ? remaining_i[5:0] : 6'(MAX_BURST);
    len_o = (cap < room) ? cap : room;
  end

endmodule

// File: rtl/raddr_channel.sv
// AXI read-address generator: walks one contiguous region in 4 KB-safe INCR bursts,
// throttled by a beat credit so in-flight read data never exceeds downstream buffering.
module raddr_channel
  import raddr_channel_pkg::*;
#(
  parameter int ID_WIDTH        = 2,
  parameter int MAX_BURST       = 32,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_pulse,
  input  logic [63:0]            src_addr,
  input  logic [23:0]            mb_num,
  input  logic                   rbeat,
  output logic                   busy,
  output logic                   done,
  raddr_channel_if.master        m_axi
);

  state_e      state_q;
  logic [63:0] addr_q;
  logic [31:0] total_q;
  logic [31:0] issued_q;
  logic [31:0] received_q;
  logic [31:0] received_d;
  logic [5:0]  len_q;
  logic [63:0] araddr_q;
  logic [7:0]  arlen_q;
  logic        arvalid_q;
  logic        busy_q;
  logic        done_q;

  logic [63:0]        base_addr;
  logic [5:0]         len;
  logic [33:0]        in_flight;
  logic signed [33:0] credit;
  logic               credit_ok;

  // Beat-aligned region base: the low address bits are discarded.
  assign base_addr = src_addr & ~64'(BEAT_BYTES - 1);

  raddr_burst_calc #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .remaining_i    (total_q - issued_q),
    .beat_in_page_i (addr_q[11:7]),
    .len_o          (len)
  );

  // Credit check: signed so a surplus of received beats never wraps into a stall.
  always_comb begin
    in_flight = {2'b00, issued_q} - {2'b00, received_q};
    credit    = $signed(34'(MAX_OUTSTANDING)) - $signed(in_flight);
    credit_ok = credit >= $signed({28'd0, len});
  end

  // Received-beat counter: counts only while an operation runs and saturates at the total.
  always_comb begin
    received_d = received_q;
    if (state_q != ST_IDLE && rbeat && received_q < total_q) begin
      received_d = received_q + 32'd1;
    end
  end

  // Main FSM with registered AR outputs, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      total_q    <= '0;
      issued_q   <= '0;
      received_q <= '0;
      len_q      <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arvalid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the later case-branch write of a register wins.
      done_q     <= 1'b0;
      received_q <= received_d;
      case (state_q)
        ST_IDLE: begin
          if (start_pulse) begin
            addr_q     <= base_addr;
            total_q    <= total_beats(mb_num);
            issued_q   <= '0;
            received_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (issued_q == total_q) begin
            state_q <= ST_DRAIN;
          end else if (credit_ok) begin
            araddr_q  <= addr_q;
            arlen_q   <= {2'b00, len} - 8'd1;
            len_q     <= len;
            arvalid_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            issued_q  <= issued_q + 32'(len_q);
            addr_q    <= addr_q + (64'(len_q) << BEAT_SHIFT);
            state_q   <= ST_CALC;
          end
        end
        ST_DRAIN: begin
          if (received_q == total_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = arlen_q;
  assign m_axi.arsize  = AXI_SIZE_128B;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arid    = '0;
  assign m_axi.arvalid = arvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
